pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Controller for the program counter register and its +4 adder.
- Each cycle it decides whether and where the PC moves: sequential, branch, jump, exception vector, stall or halt.
- Handshakes with instruction memory so the PC advances only on an accepted fetch.
- Sits between the control unit / hazard logic and the fetch stage of the MIPS datapath.

Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h0000_0080, PC loaded on exception.
- WIDTH, 32, PC and address width; only 32 is supported.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall  input  1  hazard stall; hold PC.
- branch_taken  input  1  branch resolved taken this cycle.
- branch_offset  input  32  sign-extended word offset (imm16 already extended).
- jump  input  1  J/JAL redirect this cycle.
- jump_target  input  26  instr_index field.
- exception  input  1  synchronous trap request.
- halt  input  1  stop fetching (e.g. break/syscall end-of-sim).
- imem_ack  input  1  instruction memory accepted the current address.
- imem_req  output  1  fetch request for pc_out.
- pc_out  output  32  current PC / fetch address.
- pc_plus4  output  32  pc_out + 4, combinational.
- fetch_valid  output  1  one-cycle pulse when the fetch at pc_out completes.
- flush  output  1  one-cycle pulse when a redirect is applied.
- epc  output  32  PC of the faulting fetch, captured on exception.
- fetch_count  output  32  accepted-fetch counter (see Optional Feature).

Behaviour:
- Reset (async, immediate):
  - pc_out = RESET_VECTOR; epc = 0; fetch_count = 0.
  - imem_req, fetch_valid and flush = 0.
  - state = S_BOOT; pending redirect cleared.
- FSM states: S_BOOT, S_FETCH, S_HALT.
- S_BOOT: one cycle with imem_req = 0, then unconditionally to S_FETCH.
- S_FETCH: imem_req = 1 unless stall = 1.
  - On a cycle with imem_req & imem_ack, fetch_valid = 1 that cycle.
  - Next PC is chosen at the clock edge by fixed priority:
    1. exception: EXC_VECTOR; epc <= pc_out.
    2. jump: {pc_plus4[31:28], jump_target, 2'b00}.
    3. branch_taken: pc_plus4 + (branch_offset << 2), modulo 2^32.
    4. pending redirect.
    5. pc_plus4.
  - flush = 1 in any cycle where a redirect (priorities 1–4) is loaded.
- Redirect without ack:
  - If exception, jump or branch_taken asserts while imem_ack = 0 or stall = 1, the target is latched into a pending register; flush is not asserted yet.
  - The PC holds.
  - The pending target is loaded on the next accepted fetch.
  - A later higher-or-equal priority redirect overwrites the pending target.
  - Exception always applies immediately, ignoring stall and ack, and clears pending.
- stall = 1: pc_out holds, imem_req = 0, fetch_valid = 0; redirects latch as above.
- halt = 1 in S_FETCH: enter S_HALT next cycle. PC holds, imem_req = 0, pending is kept.
- S_HALT:
  - Only exception exits: load EXC_VECTOR, go to S_FETCH.
  - halt deasserting does not exit.
- Wrap-around: pc_plus4 from 32'hFFFF_FFFC is 0; no error.
- Simultaneous halt and exception: exception wins and the block stays in S_FETCH.
- Reset mid-fetch: pc_out returns to RESET_VECTOR in the same cycle; the request is dropped.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- Defined: fetch_count increments by 1 on every fetch_valid pulse and wraps at 2^32.
- Undefined: the counter register is not built and fetch_count is tied to 0.

Decomposition:
- Package pc_seq_pkg holds:
  - state encodings S_BOOT = 2'd0, S_FETCH = 2'd1, S_HALT = 2'd2;
  - default vectors;
  - redirect-priority encoding.
- One natural sub-module: pc_target_calc, the combinational branch/jump target and pc_plus4 computation. The FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then imem_ack tied 1, no events:
  - S_BOOT for 1 cycle;
  - pc_out sequence 0, 4, 8, 12;
  - fetch_valid high each cycle from the 2nd.
- At pc 0x10, branch_taken = 1 with branch_offset = 0xFFFF_FFFE:
  - next pc = 0x14 − 8 = 0x0C;
  - flush pulses one cycle.
- At pc 0x0040_0000, jump = 1 with jump_target = 26'h010_0004:
  - next pc = 0x0040_0010;
  - branch_taken asserted in the same cycle is ignored.
- imem_ack = 0 for 3 cycles with a branch to 0x100 asserted in cycle 1:
  - pc holds;
  - the first ack loads 0x100;
  - flush is then 1.
- halt at pc 0x20, then exception 5 cycles later:
  - imem_req = 0 throughout the halt;
  - pc then = 0x80 and epc = 0x20;
  - with PC_PERF_CNT_EN, fetch_count is unchanged during the halt.
- rst asserted mid-stream at pc 0x48 with the stall/ack pending:
  - pc_out = 0 immediately, before the next clk edge;
  - pending redirect is dropped.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types for the PC sequencer: FSM states, default vectors and
// redirect priority encoding.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        S_BOOT  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0080;

    // Ordered so that a numerically larger value always wins.
    typedef enum logic [1:0] {
        PRI_NONE   = 2'd0,
        PRI_BRANCH = 2'd1,
        PRI_JUMP   = 2'd2,
        PRI_EXC    = 2'd3
    } redir_pri_t;

    function automatic redir_pri_t redirect_pri(input logic exc, input logic jmp,
                                                input logic br);
        if (exc)      return PRI_EXC;
        else if (jmp) return PRI_JUMP;
        else if (br)  return PRI_BRANCH;
        else          return PRI_NONE;
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates: sequential +4, branch and J-type targets.
module pc_target_calc #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic [25:0]      jump_target,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] jump_pc
);

    assign pc_plus4      = pc + WIDTH'(4);
    assign branch_target = pc_plus4 + (branch_offset << 2);
    assign jump_pc       = {pc_plus4[WIDTH-1:WIDTH-4], jump_target, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer with fetch handshake and pending-redirect capture.
// Optional fetch counter enabled by defining PC_PERF_CNT_EN.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
    parameter int          WIDTH        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             exception,
    input  logic             halt,
    input  logic             imem_ack,
    output logic             imem_req,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             fetch_valid,
    output logic             flush,
    output logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] fetch_count
);

    state_t           state;
    logic [WIDTH-1:0] pc_q, epc_q, pend_pc;
    redir_pri_t       pend_pri, evt_pri;
    logic             flush_q, accept;
    logic [WIDTH-1:0] br_tgt, j_tgt;

    pc_target_calc #(.WIDTH(WIDTH)) u_calc (
        .pc            (pc_q),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .pc_plus4      (pc_plus4),
        .branch_target (br_tgt),
        .jump_pc       (j_tgt)
    );

    assign imem_req    = (state == S_FETCH) && !stall && !halt;
    assign accept      = imem_req && imem_ack;
    assign fetch_valid = accept;
    assign evt_pri     = redirect_pri(exception, jump, branch_taken);

    assign pc_out = pc_q;
    assign epc    = epc_q;
    assign flush  = flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_BOOT;
            pc_q     <= RESET_VECTOR;
            epc_q    <= '0;
            pend_pc  <= '0;
            pend_pri <= PRI_NONE;
            flush_q  <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            case (state)
                S_BOOT: state <= S_FETCH;
                S_FETCH: begin
                    if (exception) begin
                        pc_q     <= EXC_VECTOR;
                        epc_q    <= pc_q;
                        pend_pri <= PRI_NONE;
                        flush_q  <= 1'b1;
                    end else if (halt) begin
                        state <= S_HALT;
                    end else if (accept) begin
                        pend_pri <= PRI_NONE;
                        if (jump) begin
                            pc_q    <= j_tgt;
                            flush_q <= 1'b1;
                        end else if (branch_taken) begin
                            pc_q    <= br_tgt;
                            flush_q <= 1'b1;
                        end else if (pend_pri != PRI_NONE) begin
                            pc_q    <= pend_pc;
                            flush_q <= 1'b1;
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end else if (evt_pri != PRI_NONE && evt_pri >= pend_pri) begin
                        // PC holds; the redirect waits for the next accepted fetch.
                        pend_pc  <= (evt_pri == PRI_JUMP) ? j_tgt : br_tgt;
                        pend_pri <= evt_pri;
                    end
                end
                S_HALT: begin
                    if (exception) begin
                        state    <= S_FETCH;
                        pc_q     <= EXC_VECTOR;
                        epc_q    <= pc_q;
                        pend_pri <= PRI_NONE;
                        flush_q  <= 1'b1;
                    end
                end
                default: state <= S_BOOT;
            endcase
        end
    end

`ifdef PC_PERF_CNT_EN
    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)              cnt_q <= '0;
        else if (fetch_valid) cnt_q <= cnt_q + WIDTH'(1);
    end

    assign fetch_count = cnt_q;
`else
    assign fetch_count = '0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer: table of per-cycle stimulus and
// expected outputs plus a hand-written asynchronous reset sequence.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch_taken, jump, exception, halt, imem_ack;
    logic [31:0] branch_offset;
    logic [25:0] jump_target;
    logic        imem_req, fetch_valid, flush;
    logic [31:0] pc_out, pc_plus4, epc, fetch_count;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] pc_prev, exp_epc, exp_cnt;

    typedef struct {
        logic        stall, br;
        logic [31:0] off;
        logic        jmp;
        logic [25:0] jt;
        logic        exc, halt, ack;
        logic        req, fv;
        logic [31:0] pc;
        logic        fl;
    } vec_t;

    vec_t tv[$];

    pc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_target   (jump_target),
        .exception     (exception),
        .halt          (halt),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .epc           (epc),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] off,
                                input logic jmp, input logic [25:0] jt, input logic exc,
                                input logic hlt, input logic ack, input logic req,
                                input logic fv, input logic [31:0] pc, input logic fl);
        vec_t v;
        v.stall = st; v.br = br; v.off = off; v.jmp = jmp; v.jt = jt;
        v.exc = exc; v.halt = hlt; v.ack = ack;
        v.req = req; v.fv = fv; v.pc = pc; v.fl = fl;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cnt_exp();
`ifdef PC_PERF_CNT_EN
        return exp_cnt;
`else
        return 32'h0;
`endif
    endfunction

    // Drive one cycle of stimulus, check combinational outputs, then registered ones.
    task automatic apply(input vec_t v, input int idx);
        stall = v.stall; branch_taken = v.br; branch_offset = v.off;
        jump = v.jmp; jump_target = v.jt; exception = v.exc;
        halt = v.halt; imem_ack = v.ack;
        #1;
        chk($sformatf("v%0d imem_req", idx), {31'b0, imem_req}, {31'b0, v.req});
        chk($sformatf("v%0d fetch_valid", idx), {31'b0, fetch_valid}, {31'b0, v.fv});
        chk($sformatf("v%0d pc_plus4", idx), pc_plus4, pc_prev + 32'd4);
        if (v.exc) exp_epc = pc_prev;
        if (v.fv) exp_cnt = exp_cnt + 32'd1;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d pc_out", idx), pc_out, v.pc);
        chk($sformatf("v%0d flush", idx), {31'b0, flush}, {31'b0, v.fl});
        chk($sformatf("v%0d epc", idx), epc, exp_epc);
        chk($sformatf("v%0d fetch_count", idx), fetch_count, cnt_exp());
        pc_prev = v.pc;
    endtask

    initial begin
        //          st br off           jmp jt          exc hlt ack req fv pc            fl
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 0, 0, 32'h0000_0000, 0)); // boot
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0004, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0008, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_000C, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0010, 0));
        tv.push_back(mk(0, 1, 32'hFFFF_FFFE,0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_000C, 1)); // back branch
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0010, 0));
        tv.push_back(mk(0, 1, 32'h0000_003B,0, 26'h0,      0, 0, 0, 1, 0, 32'h0000_0010, 0)); // branch w/o ack
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 0, 1, 0, 32'h0000_0010, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 0, 1, 0, 32'h0000_0010, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0100, 1)); // pending applied
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0104, 0));
        tv.push_back(mk(1, 0, 32'h0,        1, 26'h30,     0, 0, 1, 0, 0, 32'h0000_0104, 0)); // jump in stall
        tv.push_back(mk(1, 1, 32'h0000_0004,0, 26'h0,      0, 0, 1, 0, 0, 32'h0000_0104, 0)); // lower pri ignored
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_00C0, 1));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_00C4, 0));
        tv.push_back(mk(0, 1, 32'h0000_0008,1, 26'h10_0000,0, 0, 1, 1, 1, 32'h0040_0000, 1));
        tv.push_back(mk(0, 1, 32'h0000_0010,1, 26'h10_0004,0, 0, 1, 1, 1, 32'h0040_0010, 1)); // jump beats branch
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0040_0014, 0));
        tv.push_back(mk(1, 0, 32'h0,        0, 26'h0,      1, 0, 0, 0, 0, 32'h0000_0080, 1)); // exc ignores stall
        tv.push_back(mk(0, 0, 32'h0,        1, 26'h8,      0, 0, 1, 1, 1, 32'h0000_0020, 1));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 1, 1, 0, 0, 32'h0000_0020, 0)); // halt
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 0, 0, 32'h0000_0020, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 0, 0, 32'h0000_0020, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 0, 0, 32'h0000_0020, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 0, 0, 32'h0000_0020, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      1, 0, 1, 0, 0, 32'h0000_0080, 1)); // exc leaves halt
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0084, 0));
        tv.push_back(mk(0, 1, 32'hFFFF_FFDD,0, 26'h0,      0, 0, 1, 1, 1, 32'hFFFF_FFFC, 1));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0000, 0)); // wrap
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      1, 1, 1, 0, 0, 32'h0000_0080, 1)); // halt+exc
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0084, 0));
        tv.push_back(mk(0, 1, 32'h0000_0010,0, 26'h0,      0, 0, 0, 1, 0, 32'h0000_0084, 0));
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      1, 0, 0, 1, 0, 32'h0000_0080, 1)); // exc drops pending
        tv.push_back(mk(0, 0, 32'h0,        0, 26'h0,      0, 0, 1, 1, 1, 32'h0000_0084, 0));
        tv.push_back(mk(0, 0, 32'h0,        1, 26'h12,     0, 0, 1, 1, 1, 32'h0000_0048, 1));
        tv.push_back(mk(0, 1, 32'h0000_0004,0, 26'h0,      0, 0, 0, 1, 0, 32'h0000_0048, 0)); // pending @0x48

        stall = 0; branch_taken = 0; branch_offset = '0; jump = 0;
        jump_target = '0; exception = 0; halt = 0; imem_ack = 0;
        rst = 1'b1;
        pc_prev = 32'h0; exp_epc = 32'h0; exp_cnt = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pc_out", pc_out, 32'h0);
        chk("reset imem_req", {31'b0, imem_req}, 32'h0);
        chk("reset flush", {31'b0, flush}, 32'h0);
        chk("reset epc", epc, 32'h0);
        chk("reset fetch_count", fetch_count, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < tv.size(); i++) apply(tv[i], i);

        // Asynchronous reset while a redirect is pending at 0x48.
        stall = 0; branch_taken = 0; jump = 0; exception = 0; halt = 0; imem_ack = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("async rst pc_out", pc_out, 32'h0);
        chk("async rst imem_req", {31'b0, imem_req}, 32'h0);
        chk("async rst epc", epc, 32'h0);
        chk("async rst fetch_count", fetch_count, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pc_prev = 32'h0; exp_epc = 32'h0; exp_cnt = 32'h0;
        apply(mk(0, 0, 32'h0, 0, 26'h0, 0, 0, 1, 0, 0, 32'h0000_0000, 0), 100); // boot
        apply(mk(0, 0, 32'h0, 0, 26'h0, 0, 0, 1, 1, 1, 32'h0000_0004, 0), 101); // pending gone

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
